// File: rtl/lane_gather_pkg.sv
// Shared definitions for the lane gather pipe.
//   idx_w()        : bit-index width for a vector of n bits (never below 1)
//   MAX_IDX_W      : widest bit index a map entry can hold
//   map_entry_t    : one crossbar map entry {zero, src}
//   identity_entry : reset value of map entry d (pass bit d straight through)
package lane_gather_pkg;

   localparam int MAX_IDX_W = 16;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                 zero;
      logic [MAX_IDX_W-1:0] src;
   } map_entry_t;

   function automatic map_entry_t identity_entry(input int d);
      map_entry_t e;
      e.zero = 1'b0;
      e.src  = MAX_IDX_W'(d);
      return e;
   endfunction

endpackage

// File: rtl/lane_skid_fifo.sv
// Two-entry output buffer whose head and occupancy come straight from flops.
//   clk, rst      : clock, synchronous active-high reset
//   push          : write push_data (ignored when full)
//   push_data     : word to enqueue
//   pop           : consumer takes the head (ignored when empty)
//   not_full      : occupancy < 2, registered
//   not_empty     : occupancy > 0, registered
//   head_data     : oldest stored word, registered
module lane_skid_fifo #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          not_full,
   output logic          not_empty,
   output logic [DW-1:0] head_data
);

   logic [1:0]    count_q, count_d;
   logic [DW-1:0] head_q,  head_d;
   logic [DW-1:0] tail_q,  tail_d;
   logic          do_push, do_pop;

   assign not_full  = (count_q != 2'd2);
   assign not_empty = (count_q != 2'd0);
   assign head_data = head_q;

   assign do_push = push && not_full;
   assign do_pop  = pop  && not_empty;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (count_q)
         2'd0: begin
            if (do_push) begin
               head_d  = push_data;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            // With one word held, a simultaneous push/pop replaces the head
            // so the new word is visible on the very next cycle.
            if (do_push && do_pop) begin
               head_d = push_data;
            end else if (do_push) begin
               tail_d  = push_data;
               count_d = 2'd2;
            end else if (do_pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (do_pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/lane_gather_pipe.sv
// Bit-level gather crossbar followed by a two-entry output buffer.
// Every output bit d is either forced to 0 or copied from any input bit,
// as selected by a writable map table that resets to identity.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_data packs NUM_CH x WIDTH
//   out_valid/out_ready  : output handshake, out_data same packing
//   cfg_we               : write map entry cfg_dst with {cfg_zero, cfg_src}
module lane_gather_pipe
   import lane_gather_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 8,
   localparam int N      = NUM_CH * WIDTH,
   localparam int IW     = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_dst,
   input  logic [IW-1:0] cfg_src,
   input  logic          cfg_zero
);

   map_entry_t   map_q [N];
   map_entry_t   map_d [N];
   logic [N-1:0] routed;
   logic         cfg_ok;
   logic         fifo_not_full;
   logic         push, pop;

   // When N fills the index space exactly, every index is in range and a
   // compare would be constant, so skip it.
   if (N == (1 << IW)) begin : g_ok_full
      assign cfg_ok = 1'b1;
   end else begin : g_ok_cmp
      assign cfg_ok = (cfg_dst < IW'(N)) && (cfg_src < IW'(N));
   end

   always_comb begin
      for (int d = 0; d < N; d++) begin
         map_d[d] = map_q[d];
         if (cfg_we && cfg_ok && (cfg_dst == IW'(d))) begin
            map_d[d].zero = cfg_zero;
            map_d[d].src  = MAX_IDX_W'(cfg_src);
         end
      end
   end

   // Table updates land on the edge; the word accepted on that same edge
   // was already routed with the old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < N; d++) map_q[d] <= identity_entry(d);
      end else begin
         for (int d = 0; d < N; d++) map_q[d] <= map_d[d];
      end
   end

   for (genvar d = 0; d < N; d++) begin : g_xbar
      assign routed[d] = map_q[d].zero ? 1'b0 : in_data[map_q[d].src[IW-1:0]];
   end

   // Ready is held low while reset is asserted so no word slips in during
   // the reset cycle; it never looks at out_ready.
   assign in_ready = fifo_not_full && !rst;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   lane_skid_fifo #(
      .DW (N)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (routed),
      .pop       (pop),
      .not_full  (fifo_not_full),
      .not_empty (out_valid),
      .head_data (out_data)
   );

endmodule
